des_cbc_ctrl: RTL and testbench
===============================

// Module: des_cbc_ctrl
// PURPOSE
//   Sequencer around the combinational DES core: accepts a per-message config (key, IV, mode),
//   streams 64-bit blocks through one DES instance with valid/ready handshakes, and maintains the
//   CBC chaining register between blocks. Sits between the bus/host front end and the DES datapath.
// PARAMETERS
//   BLK_W   64  block width (fixed by DES; other values unsupported)
//   KEY_W   64  key width incl. parity bits
//   CNT_W   16  width of block counter (used only with DES_BLKCNT_EN)
// PORTS
//   clk          in   1      single clock, all state on posedge
//   reset        in   1      synchronous, active-high
//   cfg_valid    in   1      config offer
//   cfg_ready    out  1      config accepted when cfg_valid&cfg_ready
//   cfg_key      in   KEY_W  message key
//   cfg_iv       in   BLK_W  initial chaining value
//   cfg_encrypt  in   1      1=encrypt, 0=decrypt
//   cfg_cbc      in   1      1=CBC, 0=ECB
//   in_valid     in   1      input block offer
//   in_ready     out  1      input block accepted when in_valid&in_ready
//   in_data      in   BLK_W  plaintext (enc) / ciphertext (dec)
//   in_last      in   1      marks final block of message
//   out_valid    out  1      result available
//   out_ready    in   1      sink accepts result
//   out_data     out  BLK_W  DES result
//   out_last     out  1      copy of in_last for this block
//   busy         out  1      high whenever state != IDLE
//   blk_cnt      out  CNT_W  blocks completed in current message (DES_BLKCNT_EN only)
// BEHAVIOUR
//   Reset: state=IDLE; cfg_ready=1; in_ready=0; out_valid=0; out_data=0; out_last=0; busy=0;
//     key/chain/mode regs=0. Reset mid-message aborts it; pending result discarded, no out_valid.
//   FSM: IDLE -> WAIT_IN on cfg handshake (latch key, mode; chain<=cfg_iv).
//     WAIT_IN: in_ready=1; on in handshake latch in_data/in_last -> CALC.
//     CALC: core driven with (blk, key, encrypt, cbc, iv=chain); out_data<=core result;
//       chain update: enc&cbc -> chain<=core result; dec&cbc -> chain<=latched input block;
//       ECB -> chain unchanged -> HOLD.
//     HOLD: out_valid=1, out_data/out_last stable until out_ready; on handshake:
//       out_last ? IDLE : WAIT_IN.
//   Latency: in handshake at cycle N -> out_valid at N+2; min 3 cycles/block with out_ready=1.
//   cfg_ready=1 only in IDLE; cfg_valid outside IDLE ignored (key cannot change mid-message).
//   in_valid in IDLE/CALC/HOLD ignored (in_ready=0). out_ready without out_valid has no effect.
//   cfg and in handshake never occur in the same cycle (disjoint states).
//   out_valid held indefinitely under backpressure; no data loss, no re-computation.
//   Core is purely combinational; only its output is registered (in CALC).
// CONFIGURATION
//   DES_BLKCNT_EN defined: blk_cnt port present; cleared to 0 on reset and cfg handshake,
//     +1 on each out handshake, wraps at 2^CNT_W-1 -> 0.
//   Not defined: blk_cnt port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package des_ctrl_pkg: BLK_W/KEY_W constants, state enum (IDLE, WAIT_IN, CALC, HOLD),
//     mode struct {encrypt, cbc}.
//   One sub-module: existing DES core instantiated once (key, plaintext, encrypt, cbc, iv, ciphertext);
//     controller owns all registers.
// TESTING
//   1 ECB enc: key 133457799BBCDFF1, blk 0123456789ABCDEF, last=1 -> out 85E813540F0AB405
//     at N+2, out_last=1, then IDLE/cfg_ready=1.
//   2 CBC enc, iv 0000000000000000, two blocks 0123456789ABCDEF -> blk0 85E813540F0AB405;
//     blk1 = E(0123456789ABCDEF ^ 85E813540F0AB405) per software model.
//   3 CBC dec of test-2 output, same key/IV -> 0123456789ABCDEF twice; verifies chain<=input.
//   4 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid/out_data stable, in_ready=0;
//     cfg_valid pulsed meanwhile ignored.
//   5 Reset asserted in CALC of block 2 -> next cycle all outputs at reset values; new message
//     with new IV produces correct blk0 (no stale chain).
//   6 DES_BLKCNT_EN, CNT_W=2: 5-block message -> blk_cnt 1,2,3,0,1; new cfg clears to 0.

Source files
------------

// File: rtl/des_ctrl_pkg.sv
// Shared definitions for the DES block sequencer.
//   BLK_W / KEY_W : DES block and key widths (key includes parity bits)
//   state_t       : controller states IDLE, WAIT_IN, CALC, HOLD
//   mode_t        : per-message mode {encrypt, cbc}
package des_ctrl_pkg;

    localparam int BLK_W = 64;
    localparam int KEY_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        CALC    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    typedef struct packed {
        logic encrypt;
        logic cbc;
    } mode_t;

endpackage

// File: rtl/des_cbc_ctrl_core.sv
// Combinational DES core with CBC pre/post whitening.
//   key        in  KEY_W  key incl. parity bits (parity ignored)
//   plaintext  in  BLK_W  input block (plaintext for enc, ciphertext for dec)
//   encrypt    in  1      1=encrypt, 0=decrypt
//   cbc        in  1      1=XOR iv before enc / after dec
//   iv         in  BLK_W  chaining value
//   ciphertext out BLK_W  result block
// Bit numbering follows the DES standard: bit 1 is the MSB of each vector.
module des_cbc_ctrl_core
    import des_ctrl_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] plaintext,
    input  logic             encrypt,
    input  logic             cbc,
    input  logic [BLK_W-1:0] iv,
    output logic [BLK_W-1:0] ciphertext
);

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // S1..S8, each 64 nibbles indexed {row, col}, first entry at the MSB end.
    localparam logic [2047:0] SBOX = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    // IP table is regular: rows start at 58,60,62,64,57,59,61,63 and step by -8.
    function automatic int ip_tbl(input int k);
        int r, c;
        r = k / 8;
        c = k % 8;
        return ((r < 4) ? 58 + 2 * r : 49 + 2 * r) - 8 * c;
    endfunction

    function automatic logic [63:0] init_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[63-k] = x[64-ip_tbl(k)];
        return y;
    endfunction

    // Final permutation is the inverse of IP.
    function automatic logic [63:0] final_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[64-ip_tbl(k)] = x[63-k];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int k = 0; k < 56; k++) y[55-k] = x[64-PC1_T[k]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y[47-k] = x[56-PC2_T[k]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] so, y;
        logic [5:0]  s6;
        int          idx;
        e  = '0;
        so = '0;
        y  = '0;
        // Expansion: box j takes bits 4j..4j+5 (1-based, wrapping 0 -> 32, 33 -> 1).
        for (int i = 0; i < 48; i++) e[47-i] = r[32 - ((4 * (i / 6) + i % 6 + 31) % 32 + 1)];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            s6  = e[47-6*j -: 6];
            idx = int'({s6[5], s6[0], s6[4:1]});
            so[31-4*j -: 4] = SBOX[2047 - 256 * j - 4 * idx -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = so[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_crypt(input logic [63:0] k, input logic [63:0] blk,
                                              input logic enc);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk [16];
        logic [63:0] x;
        logic [31:0] l, r, t;
        cd = pc1(k);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            c = (SHIFT_T[i] == 1) ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
            d = (SHIFT_T[i] == 1) ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
            sk[i] = pc2({c, d});
        end
        x = init_perm(blk);
        l = x[63:32];
        r = x[31:0];
        // Decryption is the same network with the subkey order reversed.
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ feistel(r, enc ? sk[i] : sk[15-i]);
            l = t;
        end
        return final_perm({r, l});
    endfunction

    logic [BLK_W-1:0] din, dout;
    logic             unused_parity;

    assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

    always_comb begin
        din        = (encrypt && cbc) ? (plaintext ^ iv) : plaintext;
        dout       = des_crypt(key, din, encrypt);
        ciphertext = (!encrypt && cbc) ? (dout ^ iv) : dout;
    end

endmodule

// File: rtl/des_cbc_ctrl.sv
// DES message sequencer: takes a per-message config (key, IV, mode), streams
// blocks through one combinational DES core with valid/ready handshakes and
// keeps the CBC chaining register between blocks.
//   clk, reset            clock, synchronous active-high reset
//   cfg_valid/cfg_ready   config handshake (key, iv, encrypt, cbc); ready only in IDLE
//   in_valid/in_ready     input block handshake (in_data, in_last)
//   out_valid/out_ready   result handshake (out_data, out_last)
//   busy                  high whenever a message is in progress
//   blk_cnt               blocks completed in this message (only with DES_BLKCNT_EN)
// Build option: define DES_BLKCNT_EN to add the blk_cnt port and counter.
module des_cbc_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             cfg_encrypt,
    input  logic             cfg_cbc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
`ifdef DES_BLKCNT_EN
    ,
    output logic [CNT_W-1:0] blk_cnt
`endif
);

    state_t           state, state_nxt;
    logic [KEY_W-1:0] key_q;
    mode_t            mode_q;
    logic [BLK_W-1:0] chain_q, blk_q, out_data_q, core_out;
    logic             last_q;
    logic             cfg_fire, in_fire, out_fire;

    des_cbc_ctrl_core u_core (
        .key        (key_q),
        .plaintext  (blk_q),
        .encrypt    (mode_q.encrypt),
        .cbc        (mode_q.cbc),
        .iv         (chain_q),
        .ciphertext (core_out)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = WAIT_IN;
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_q ? IDLE : WAIT_IN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cfg_fire = cfg_valid & cfg_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign busy     = (state != IDLE);
    assign out_data = out_data_q;
    // last_q only changes on an input handshake, so it is stable through HOLD.
    assign out_last = last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q      <= '0;
            mode_q     <= '0;
            chain_q    <= '0;
            blk_q      <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (cfg_fire) begin
                key_q          <= cfg_key;
                mode_q.encrypt <= cfg_encrypt;
                mode_q.cbc     <= cfg_cbc;
                chain_q        <= cfg_iv;
            end
            if (in_fire) begin
                blk_q  <= in_data;
                last_q <= in_last;
            end
            if (state == CALC) begin
                out_data_q <= core_out;
                // Encrypt chains on its own output, decrypt on the ciphertext it consumed.
                if (mode_q.cbc) chain_q <= mode_q.encrypt ? core_out : blk_q;
            end
        end
    end

`ifdef DES_BLKCNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || cfg_fire) cnt_q <= '0;
        else if (out_fire)     cnt_q <= cnt_q + 1'b1;
    end

    assign blk_cnt = cnt_q;
`else
    logic unused_out_fire;
    assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Directed bench for des_cbc_ctrl. Expected values derive from the classic
// vector E(133457799BBCDFF1, 0123456789ABCDEF) = 85E813540F0AB405, its
// complement-property twin, and CBC inputs chosen so that each chained DES
// input equals that known plaintext.
module tb_des_cbc_ctrl;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] P2  = 64'h84CB563386A179EA;  // P1 ^ C1
    localparam logic [63:0] KN  = 64'hECCBA8866443200E;  // ~K1
    localparam logic [63:0] PN  = 64'hFEDCBA9876543210;  // ~P1
    localparam logic [63:0] CN  = 64'h7A17ECABF0F54BFA;  // ~C1
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [63:0] cfg_key = '0, cfg_iv = '0;
    logic        cfg_encrypt = 1'b0, cfg_cbc = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last, busy;
`ifdef DES_BLKCNT_EN
    logic [1:0]  blk_cnt;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    des_cbc_ctrl #(.CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_key     (cfg_key),
        .cfg_iv      (cfg_iv),
        .cfg_encrypt (cfg_encrypt),
        .cfg_cbc     (cfg_cbc),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
`ifdef DES_BLKCNT_EN
        ,
        .blk_cnt     (blk_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input string tag, input logic [63:0] k, input logic [63:0] iv,
                            input logic enc, input logic cbc);
        int n = 0;
        cfg_valid = 1'b1; cfg_key = k; cfg_iv = iv; cfg_encrypt = enc; cfg_cbc = cbc;
        while (!cfg_ready && n < 50) begin tick(); n++; end
        chk({tag, " cfg_ready"}, 64'(cfg_ready), 64'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_blk(input string tag, input logic [63:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_out(input string tag, input logic [63:0] d, input logic l);
        int n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " out_data"}, out_data, d);
        chk({tag, " out_last"}, 64'(out_last), 64'(l));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        chk("rst cfg_ready", 64'(cfg_ready), 64'd1);
        chk("rst in_ready",  64'(in_ready),  64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data",  out_data,       64'd0);
        chk("rst out_last",  64'(out_last),  64'd0);
        chk("rst busy",      64'(busy),      64'd0);

        // 1: ECB encrypt, latency N+2, back to IDLE
        send_cfg("t1", K1, 64'd0, 1'b1, 1'b0);
        chk("t1 busy",      64'(busy),      64'd1);
        chk("t1 cfg_ready", 64'(cfg_ready), 64'd0);
        send_blk("t1", P1, 1'b1);
        chk("t1 N+1 valid", 64'(out_valid), 64'd0);
        chk("t1 N+1 in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("t1 N+2 valid", 64'(out_valid), 64'd1);
        get_out("t1", C1, 1'b1);
        chk("t1 idle cfg_ready", 64'(cfg_ready), 64'd1);
        chk("t1 idle busy",      64'(busy),      64'd0);

        // ECB complement vector and ECB decrypt
        send_cfg("ecbn", KN, 64'd0, 1'b1, 1'b0);
        send_blk("ecbn", PN, 1'b1);
        get_out("ecbn", CN, 1'b1);
        send_cfg("ecbd", K1, 64'd0, 1'b0, 1'b0);
        send_blk("ecbd", C1, 1'b1);
        get_out("ecbd", P1, 1'b1);

        // 2: CBC encrypt, chain <= result
        send_cfg("t2", K1, 64'd0, 1'b1, 1'b1);
        send_blk("t2 b0", P1, 1'b0);
        get_out("t2 b0", C1, 1'b0);
        send_blk("t2 b1", P2, 1'b1);
        get_out("t2 b1", C1, 1'b1);

        // 3: CBC decrypt, chain <= input block
        send_cfg("t3", K1, 64'd0, 1'b0, 1'b1);
        send_blk("t3 b0", C1, 1'b0);
        get_out("t3 b0", P1, 1'b0);
        send_blk("t3 b1", C1, 1'b1);
        get_out("t3 b1", P2, 1'b1);

        // 4: backpressure with ignored cfg / in offers
        send_cfg("t4", K1, 64'd0, 1'b1, 1'b0);
        send_blk("t4", P1, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            cfg_valid = (i >= 3 && i < 6);
            cfg_key   = KN;
            in_valid  = 1'b1;
            in_data   = PN;
            tick();
            chk("t4 hold valid", 64'(out_valid), 64'd1);
            chk("t4 hold data",  out_data,       C1);
            chk("t4 in_ready",   64'(in_ready),  64'd0);
            chk("t4 cfg_ready",  64'(cfg_ready), 64'd0);
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        get_out("t4 rel", C1, 1'b1);
        chk("t4 idle busy", 64'(busy), 64'd0);

        // 5: reset during CALC of the second block, then fresh message
        send_cfg("t5", K1, 64'd0, 1'b1, 1'b1);
        send_blk("t5 b0", P1, 1'b0);
        get_out("t5 b0", C1, 1'b0);
        send_blk("t5 b1", P2, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5 rst out_valid", 64'(out_valid), 64'd0);
        chk("t5 rst out_data",  out_data,       64'd0);
        chk("t5 rst out_last",  64'(out_last),  64'd0);
        chk("t5 rst cfg_ready", 64'(cfg_ready), 64'd1);
        chk("t5 rst in_ready",  64'(in_ready),  64'd0);
        chk("t5 rst busy",      64'(busy),      64'd0);
        tick();
        chk("t5 rst+1 out_valid", 64'(out_valid), 64'd0);
        send_cfg("t5n", K1, ONES, 1'b1, 1'b1);
        send_blk("t5n", PN, 1'b1);
        get_out("t5n", C1, 1'b1);

`ifdef DES_BLKCNT_EN
        // 6: counter wraps at 2 bits, cleared on cfg
        send_cfg("t6", K1, 64'd0, 1'b1, 1'b0);
        chk("t6 cnt start", 64'(blk_cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            send_blk("t6", P1, (i == 4));
            get_out("t6", C1, (i == 4));
            chk("t6 cnt", 64'(blk_cnt), 64'((i + 1) % 4));
        end
        send_cfg("t6 clr", K1, 64'd0, 1'b1, 1'b0);
        chk("t6 cnt clr", 64'(blk_cnt), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
